multiword_adder: RTL and testbench

MULTIWORD_ADDER -- requirements
Module: multiword_adder

---
 rtl/addition_pkg.sv | 11 +
 rtl/carry_lookahead_adder.sv | 28 ++
 rtl/multiword_adder.sv | 129 ++++++++++++
 tb/tb_multiword_adder.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/addition_pkg.sv
// Shared constants for the multiword adder: FSM state encodings and default sizing.
package addition_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_WORDS = 4;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/carry_lookahead_adder.sv
// WIDTH-bit carry-lookahead adder built from per-bit generate/propagate terms.
module carry_lookahead_adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH-1:0] gen;
    logic [WIDTH-1:0] prop;
    logic [WIDTH:0]   carry;

    always_comb begin
        gen      = a & b;
        prop     = a ^ b;
        carry    = '0;
        carry[0] = cin;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            carry[i+1] = gen[i] | (prop[i] & carry[i]);
        end
        sum  = prop ^ carry[WIDTH-1:0];
        cout = carry[WIDTH];
    end

endmodule

// File: rtl/multiword_adder.sv
// Sequential multiword adder: one WIDTH-bit chunk per cycle, LSB chunk first.
// Define MULTIWORD_ADDER_OVERFLOW_EN to add the signed overflow output.
module multiword_adder
    import addition_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int WORDS = DEF_WORDS
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH*WORDS-1:0] a,
    input  logic [WIDTH*WORDS-1:0] b,
    input  logic                   carry_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH*WORDS-1:0] sum,
    output logic                   carry_out
`ifdef MULTIWORD_ADDER_OVERFLOW_EN
    ,
    output logic                   overflow
`endif
);

    localparam int TOTAL = WIDTH * WORDS;
    localparam int CW    = $clog2(WORDS) + 1;
    localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [TOTAL-1:0] a_q, a_d;
    logic [TOTAL-1:0] b_q, b_d;
    logic [TOTAL-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic [WIDTH-1:0] chunk_a, chunk_b, chunk_sum;
    logic             chunk_cout;

    // Counter stops at WORDS-1, so the chunk select never leaves the operand.
    always_comb begin
        chunk_a = a_q[int'(cnt_q)*WIDTH +: WIDTH];
        chunk_b = b_q[int'(cnt_q)*WIDTH +: WIDTH];
    end

    carry_lookahead_adder #(
        .WIDTH(WIDTH)
    ) u_cla (
        .a   (chunk_a),
        .b   (chunk_b),
        .cin (carry_q),
        .sum (chunk_sum),
        .cout(chunk_cout)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = carry_in;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[int'(cnt_q)*WIDTH +: WIDTH] = chunk_sum;
                carry_d = chunk_cout;
                if (cnt_q == LAST) begin
                    cout_d  = chunk_cout;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        sum       = sum_q;
        carry_out = cout_q;
    end

`ifdef MULTIWORD_ADDER_OVERFLOW_EN
    always_comb begin
        overflow = (state_q == DONE) &&
                   (a_q[TOTAL-1] == b_q[TOTAL-1]) &&
                   (sum_q[TOTAL-1] != a_q[TOTAL-1]);
    end
`endif

endmodule

// File: tb/tb_multiword_adder.sv
// Directed self-checking bench for multiword_adder (WIDTH=8, WORDS=4).
module tb_multiword_adder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        carry_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        carry_out;
`ifdef MULTIWORD_ADDER_OVERFLOW_EN
    logic        overflow;
`endif

    int errors = 0;
    int checks = 0;

    multiword_adder #(
        .WIDTH(8),
        .WORDS(4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .carry_in (carry_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .carry_out(carry_out)
`ifdef MULTIWORD_ADDER_OVERFLOW_EN
        ,
        .overflow (overflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Offer one operation, scramble operands while it runs, wait for out_valid.
    task automatic start_op(input logic [31:0] av, input logic [31:0] bv,
                            input logic cv, output int lat);
        @(negedge clk);
        in_valid = 1'b1;
        a        = av;
        b        = bv;
        carry_in = cv;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = ~av;
        b        = bv ^ 32'hA5A5_5A5A;
        carry_in = ~cv;
        lat      = 0;
        while (lat < 20) begin
            @(posedge clk);
            lat++;
            #1;
            if (out_valid) break;
        end
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
        checks++;
        if (sum !== 32'h0 || carry_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_sum: sum=%h cout=%b required 0/0", sum, carry_out);
        end
    endtask

    task automatic test_basic();
        int lat;
        start_op(32'h1234_5678, 32'h1111_1111, 1'b0, lat);
        checks++;
        if (lat !== 4) begin
            errors++;
            $display("FAIL basic_latency: got %0d required 4", lat);
        end
        @(negedge clk);
        checks++;
        if (sum !== 32'h2345_6789 || carry_out !== 1'b0) begin
            errors++;
            $display("FAIL basic_sum: sum=%h cout=%b required 23456789/0", sum, carry_out);
        end
`ifdef MULTIWORD_ADDER_OVERFLOW_EN
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL basic_ovf: got %b required 0", overflow);
        end
`endif
        consume();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_release: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_ripple();
        int lat;
        start_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, lat);
        @(negedge clk);
        checks++;
        if (lat !== 4 || sum !== 32'h0 || carry_out !== 1'b1) begin
            errors++;
            $display("FAIL ripple: lat=%0d sum=%h cout=%b required 4/00000000/1", lat, sum, carry_out);
        end
        consume();
    endtask

    task automatic test_carry_in();
        int lat;
        start_op(32'h0, 32'h0, 1'b1, lat);
        @(negedge clk);
        checks++;
        if (lat !== 4 || sum !== 32'h0000_0001 || carry_out !== 1'b0) begin
            errors++;
            $display("FAIL carry_in: lat=%0d sum=%h cout=%b required 4/00000001/0", lat, sum, carry_out);
        end
        consume();
    endtask

    task automatic test_hold();
        int lat;
        start_op(32'h0F0F_0F0F, 32'h1010_1010, 1'b0, lat);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a = 32'hDEAD_0000 + i;
            b = 32'h0000_BEEF << i;
            checks++;
            if (sum !== 32'h1F1F_1F1F || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_%0d: sum=%h out_valid=%b in_ready=%b required 1f1f1f1f/1/0",
                         i, sum, out_valid, in_ready);
            end
        end
        consume();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL hold_release: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        @(negedge clk);
        in_valid = 1'b1;
        a        = 32'h5555_5555;
        b        = 32'h5555_5555;
        carry_in = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || sum !== 32'h0 || in_ready !== 1'b1 || carry_out !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: out_valid=%b sum=%h in_ready=%b cout=%b required 0/0/1/0",
                     out_valid, sum, in_ready, carry_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        lat   = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) lat++;
        end
        checks++;
        if (lat !== 0) begin
            errors++;
            $display("FAIL reset_discard: out_valid seen %0d cycles required 0", lat);
        end
        start_op(32'h8765_4321, 32'h1234_5678, 1'b1, lat);
        @(negedge clk);
        checks++;
        if (lat !== 4 || sum !== 32'h9999_999A || carry_out !== 1'b0) begin
            errors++;
            $display("FAIL after_reset: lat=%0d sum=%h cout=%b required 4/9999999a/0", lat, sum, carry_out);
        end
        consume();
    endtask

    task automatic test_back_to_back();
        int lat;
        start_op(32'h8000_0000, 32'h8000_0000, 1'b0, lat);
        @(negedge clk);
        checks++;
        if (sum !== 32'h0 || carry_out !== 1'b1) begin
            errors++;
            $display("FAIL b2b_sum: sum=%h cout=%b required 00000000/1", sum, carry_out);
        end
`ifdef MULTIWORD_ADDER_OVERFLOW_EN
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ovf: got %b required 1", overflow);
        end
`endif
        in_valid  = 1'b1;
        a         = 32'h0000_0002;
        b         = 32'h0000_0003;
        carry_in  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL no_reaccept: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat      = 0;
        while (lat < 20) begin
            @(posedge clk);
            lat++;
            #1;
            if (out_valid) break;
        end
        @(negedge clk);
        checks++;
        if (lat !== 4 || sum !== 32'h0000_0005 || carry_out !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second: lat=%0d sum=%h cout=%b required 4/00000005/0", lat, sum, carry_out);
        end
        consume();
    endtask

    task automatic test_overflow();
        int lat;
        start_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, lat);
        @(negedge clk);
        checks++;
        if (lat !== 4 || sum !== 32'h8000_0000 || carry_out !== 1'b0) begin
            errors++;
            $display("FAIL ovf_sum: lat=%0d sum=%h cout=%b required 4/80000000/0", lat, sum, carry_out);
        end
`ifdef MULTIWORD_ADDER_OVERFLOW_EN
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_flag: got %b required 1", overflow);
        end
`endif
        consume();
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        carry_in  = 1'b0;
        #12;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_basic();
        test_ripple();
        test_carry_in();
        test_hold();
        test_reset_mid_run();
        test_back_to_back();
        test_overflow();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
